// File: rtl/atm_pkg.sv
// Shared types and constants for the ATM controller: FSM state encoding and
// active-low seven-segment codes in {g,f,e,d,c,b,a} order.
package atm_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PASS   = 3'd1,
        ST_MENU   = 3'd2,
        ST_MONEY  = 3'd3,
        ST_PW_OLD = 3'd4,
        ST_PW_NEW = 3'd5,
        ST_LOCK   = 3'd6
    } state_e;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Codes 10..15 have no glyph and show as blank.
    function automatic logic [6:0] seg_code(input logic [3:0] val);
        case (val)
            4'd0:    return SEG_0;
            4'd1:    return SEG_1;
            4'd2:    return SEG_2;
            4'd3:    return SEG_3;
            4'd4:    return SEG_4;
            4'd5:    return SEG_5;
            4'd6:    return SEG_6;
            4'd7:    return SEG_7;
            4'd8:    return SEG_8;
            4'd9:    return SEG_9;
            default: return SEG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/atm_seg7_dec.sv
// Decimal digit to active-low seven-segment code, with a forced-blank input.
module atm_seg7_dec
    import atm_pkg::*;
(
    input  logic [3:0] val_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    assign seg_o = blank_i ? SEG_BLANK : seg_code(val_i);

endmodule

// File: rtl/atm.sv
// Single-account ATM controller: button-driven FSM with PIN check, deposit,
// withdraw, PIN change and timed lockouts; LED state display and 4-digit 7-seg.
module atm
    import atm_pkg::*;
#(
    parameter int unsigned LOCK_LONG_CYCLES  = 500_000_000,
    parameter int unsigned LOCK_SHORT_CYCLES = 250_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       BTN3,
    input  logic       BTN2,
    input  logic       BTN1,
    input  logic [3:0] SW,
    output logic [7:0] LED,
    output logic [6:0] digit4,
    output logic [6:0] digit3,
    output logic [6:0] digit2,
    output logic [6:0] digit1
);

    // Counter is loaded with N-1 so the lock lasts exactly N clocks.
    localparam logic [31:0] LONG_LOAD  = 32'(LOCK_LONG_CYCLES - 1);
    localparam logic [31:0] SHORT_LOAD = 32'(LOCK_SHORT_CYCLES - 1);

    state_e      state_q, state_d;
    state_e      ret_q, ret_d;
    logic [3:0]  pin_q, pin_d;
    logic [7:0]  bal_q, bal_d;
    logic [1:0]  att_q, att_d;
    logic [31:0] cnt_q, cnt_d;
    logic        long_q, long_d;
    logic [2:0]  prev_q;

    logic [2:0]  btn;
    logic [2:0]  press;
    logic        p1, p2, p3;
    logic [8:0]  dep_sum;
    logic        pin_ok;
    logic        last_try;

    assign btn      = {BTN3, BTN2, BTN1};
    assign press    = btn & ~prev_q;
    assign p1       = press[0];
    assign p2       = press[1] & ~press[0];
    assign p3       = press[2] & ~press[1] & ~press[0];
    assign dep_sum  = {1'b0, bal_q} + {5'b0_0000, SW};
    assign pin_ok   = (SW == pin_q);
    assign last_try = (att_q == 2'd2);

    always_comb begin
        state_d = state_q;
        ret_d   = ret_q;
        pin_d   = pin_q;
        bal_d   = bal_q;
        att_d   = att_q;
        cnt_d   = cnt_q;
        long_d  = long_q;
        case (state_q)
            ST_IDLE: begin
                if (p3) state_d = ST_PASS;
            end
            ST_PASS: begin
                if (p1) begin
                    state_d = ST_IDLE;
                    att_d   = 2'd0;
                end else if (p3) begin
                    if (pin_ok) begin
                        state_d = ST_MENU;
                        att_d   = 2'd0;
                    end else begin
                        att_d = att_q + 2'd1;
                        if (last_try) begin
                            state_d = ST_LOCK;
                            cnt_d   = LONG_LOAD;
                            ret_d   = ST_IDLE;
                            long_d  = 1'b1;
                        end
                    end
                end
            end
            ST_MENU: begin
                if (p1)      state_d = ST_IDLE;
                else if (p2) state_d = ST_PW_OLD;
                else if (p3) state_d = ST_MONEY;
            end
            ST_MONEY: begin
                if (p1) begin
                    state_d = ST_MENU;
                end else if (p2) begin
                    if ({4'b0000, SW} <= bal_q) begin
                        bal_d = bal_q - {4'b0000, SW};
                    end else begin
                        state_d = ST_LOCK;
                        cnt_d   = SHORT_LOAD;
                        ret_d   = ST_MONEY;
                        long_d  = 1'b0;
                    end
                end else if (p3) begin
                    if (!dep_sum[8]) bal_d = dep_sum[7:0];
                end
            end
            ST_PW_OLD: begin
                if (p1) begin
                    state_d = ST_MENU;
                end else if (p3) begin
                    if (pin_ok) begin
                        state_d = ST_PW_NEW;
                        att_d   = 2'd0;
                    end else begin
                        att_d = att_q + 2'd1;
                        if (last_try) begin
                            state_d = ST_LOCK;
                            cnt_d   = LONG_LOAD;
                            ret_d   = ST_IDLE;
                            long_d  = 1'b1;
                        end
                    end
                end
            end
            ST_PW_NEW: begin
                if (p1) begin
                    state_d = ST_MENU;
                end else if (p3) begin
                    pin_d   = SW;
                    state_d = ST_MENU;
                end
            end
            ST_LOCK: begin
                if (cnt_q == 32'd0) begin
                    state_d = ret_q;
                    if (ret_q == ST_IDLE) att_d = 2'd0;
                end else begin
                    cnt_d = cnt_q - 32'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            ret_q   <= ST_IDLE;
            pin_q   <= 4'b0000;
            bal_q   <= 8'd0;
            att_q   <= 2'd0;
            cnt_q   <= 32'd0;
            long_q  <= 1'b0;
            prev_q  <= 3'b000;
        end else begin
            state_q <= state_d;
            ret_q   <= ret_d;
            pin_q   <= pin_d;
            bal_q   <= bal_d;
            att_q   <= att_d;
            cnt_q   <= cnt_d;
            long_q  <= long_d;
            prev_q  <= btn;
        end
    end

    always_comb begin
        LED = 8'b0000_0000;
        case (state_q)
            ST_IDLE:   LED[0] = 1'b1;
            ST_PASS:   LED[1] = 1'b1;
            ST_MENU:   LED[2] = 1'b1;
            ST_MONEY:  LED[3] = 1'b1;
            ST_PW_OLD: LED[4] = 1'b1;
            ST_PW_NEW: LED[5] = 1'b1;
            ST_LOCK:   LED[6] = 1'b1;
            default:   LED    = 8'b0000_0000;
        endcase
        LED[7] = (state_q == ST_LOCK) && long_q;
    end

    logic       show_att, show_bal;
    logic [3:0] hund, tens, units;

    assign show_att = (state_q == ST_PASS) || (state_q == ST_PW_OLD) || (state_q == ST_LOCK);
    assign show_bal = (state_q == ST_MENU) || (state_q == ST_MONEY);
    assign hund     = 4'(bal_q / 8'd100);
    assign tens     = 4'((bal_q / 8'd10) % 8'd10);
    assign units    = 4'(bal_q % 8'd10);

    atm_seg7_dec u_dig4 (.val_i({2'b00, att_q}), .blank_i(!show_att), .seg_o(digit4));
    atm_seg7_dec u_dig3 (.val_i(hund),           .blank_i(!show_bal), .seg_o(digit3));
    atm_seg7_dec u_dig2 (.val_i(tens),           .blank_i(!show_bal), .seg_o(digit2));
    atm_seg7_dec u_dig1 (.val_i(units),          .blank_i(!show_bal), .seg_o(digit1));

endmodule

// File: tb/tb_atm.sv
// Bench for atm: directed walk through the main scenarios followed by random
// button/switch traffic, all compared cycle by cycle against a behavioural model.
module tb_atm;

    localparam int LONG  = 80;
    localparam int SHORT = 40;

    localparam int M_IDLE = 0, M_PASS = 1, M_MENU = 2, M_MONEY = 3,
                   M_PW_OLD = 4, M_PW_NEW = 5, M_LOCK = 6;

    localparam logic [2:0] B3 = 3'b100, B2 = 3'b010, B1 = 3'b001, B0 = 3'b000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       BTN3 = 1'b0, BTN2 = 1'b0, BTN1 = 1'b0;
    logic [3:0] SW = 4'd0;
    logic [7:0] LED;
    logic [6:0] digit4, digit3, digit2, digit1;

    atm #(.LOCK_LONG_CYCLES(LONG), .LOCK_SHORT_CYCLES(SHORT)) dut (
        .clk(clk), .rst(rst), .BTN3(BTN3), .BTN2(BTN2), .BTN1(BTN1), .SW(SW),
        .LED(LED), .digit4(digit4), .digit3(digit3), .digit2(digit2), .digit1(digit1)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model of the account and user session
    int         m_mode, m_ret, m_pin, m_bal, m_att, m_left;
    bit         m_long;
    logic [2:0] m_prev;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [6:0] seg_of(input int v);
        case (v)
            0: return 7'b1000000;
            1: return 7'b1111001;
            2: return 7'b0100100;
            3: return 7'b0110000;
            4: return 7'b0011001;
            5: return 7'b0010010;
            6: return 7'b0000010;
            7: return 7'b1111000;
            8: return 7'b0000000;
            9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    task automatic model_reset();
        m_mode = M_IDLE; m_ret = M_IDLE; m_pin = 0; m_bal = 0; m_att = 0;
        m_left = 0; m_long = 0; m_prev = 3'b000;
    endtask

    task automatic enter_lock(input int len, input int ret, input bit is_long);
        m_mode = M_LOCK; m_left = len; m_ret = ret; m_long = is_long;
    endtask

    task automatic wrong_pin();
        m_att++;
        if (m_att == 3) enter_lock(LONG, M_IDLE, 1'b1);
    endtask

    task automatic model_edge(input logic [2:0] b, input int sw);
        logic [2:0] p;
        int key;
        p = b & ~m_prev;
        m_prev = b;
        key = p[0] ? 1 : p[1] ? 2 : p[2] ? 3 : 0;
        if (m_mode == M_LOCK) begin
            m_left--;
            if (m_left == 0) begin
                m_mode = m_ret;
                if (m_ret == M_IDLE) m_att = 0;
            end
        end else begin
            case (m_mode)
                M_IDLE:   if (key == 3) m_mode = M_PASS;
                M_PASS: begin
                    if (key == 1) begin m_mode = M_IDLE; m_att = 0; end
                    else if (key == 3) begin
                        if (sw == m_pin) begin m_mode = M_MENU; m_att = 0; end
                        else wrong_pin();
                    end
                end
                M_MENU: begin
                    if (key == 1) m_mode = M_IDLE;
                    else if (key == 2) m_mode = M_PW_OLD;
                    else if (key == 3) m_mode = M_MONEY;
                end
                M_MONEY: begin
                    if (key == 1) m_mode = M_MENU;
                    else if (key == 2) begin
                        if (sw <= m_bal) m_bal = m_bal - sw;
                        else enter_lock(SHORT, M_MONEY, 1'b0);
                    end else if (key == 3) begin
                        if (m_bal + sw <= 255) m_bal = m_bal + sw;
                    end
                end
                M_PW_OLD: begin
                    if (key == 1) m_mode = M_MENU;
                    else if (key == 3) begin
                        if (sw == m_pin) begin m_mode = M_PW_NEW; m_att = 0; end
                        else wrong_pin();
                    end
                end
                M_PW_NEW: begin
                    if (key == 1) m_mode = M_MENU;
                    else if (key == 3) begin m_pin = sw; m_mode = M_MENU; end
                end
                default: m_mode = M_IDLE;
            endcase
        end
    endtask

    task automatic check_outputs();
        logic [7:0] e_led;
        bit show_att, show_bal;
        e_led = 8'(1) << m_mode;
        if (m_mode == M_LOCK && m_long) e_led[7] = 1'b1;
        show_att = (m_mode == M_PASS) || (m_mode == M_PW_OLD) || (m_mode == M_LOCK);
        show_bal = (m_mode == M_MENU) || (m_mode == M_MONEY);
        chk("led", LED, e_led);
        chk("digit4", digit4, show_att ? seg_of(m_att) : seg_of(-1));
        chk("digit3", digit3, show_bal ? seg_of(m_bal / 100) : seg_of(-1));
        chk("digit2", digit2, show_bal ? seg_of((m_bal / 10) % 10) : seg_of(-1));
        chk("digit1", digit1, show_bal ? seg_of(m_bal % 10) : seg_of(-1));
    endtask

    // Called at a falling edge; drives inputs for one rising edge and checks after it.
    task automatic step(input logic [2:0] b, input logic [3:0] sw);
        BTN3 = b[2]; BTN2 = b[1]; BTN1 = b[0]; SW = sw;
        @(posedge clk);
        model_edge(b, int'(sw));
        #1;
        check_outputs();
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] b, input logic [3:0] sw);
        step(b, sw);
        step(B0, sw);
    endtask

    // Asynchronous reset asserted mid-cycle; outputs must change without a clock.
    task automatic do_reset();
        BTN3 = 1'b0; BTN2 = 1'b0; BTN1 = 1'b0;
        #2 rst = 1'b0;
        #1;
        model_reset();
        check_outputs();
        chk("reset_led", LED, 8'b0000_0001);
        chk("reset_blank", digit1, 7'b1111111);
        @(negedge clk);
        rst = 1'b1;
    endtask

    // Caller has just seen the entry edge; counts lock cycles while poking BTN3.
    task automatic count_lock(input logic [7:0] led_val, input int exp_len, input string tag);
        int n;
        n = 1;
        for (int i = 0; i < 300; i++) begin
            step((i % 2 == 0) ? B3 : B0, SW);
            if (LED === led_val) n++;
            else break;
        end
        chk(tag, n, exp_len);
        step(B0, SW);
    endtask

    initial begin
        model_reset();
        @(negedge clk);
        do_reset();

        // Login with default PIN, deposit 5
        press(B3, 4'd0);
        chk("pass_led", LED, 8'b0000_0010);
        chk("pass_att0", digit4, 7'b1000000);
        press(B3, 4'd0);
        press(B3, 4'd0);
        press(B3, 4'd5);
        chk("money_led", LED, 8'b0000_1000);
        chk("bal_d3", digit3, 7'b1000000);
        chk("bal_d2", digit2, 7'b1000000);
        chk("bal_d1", digit1, 7'b0010010);

        // Change PIN to 9 and log out
        press(B1, 4'd0);
        press(B2, 4'd0);
        press(B3, 4'd0);
        press(B3, 4'd9);
        chk("menu_led", LED, 8'b0000_0100);
        press(B1, 4'd0);
        chk("logout_led", LED, 8'b0000_0001);

        // Three wrong PINs -> long lock
        press(B3, 4'd0);
        press(B3, 4'd0);
        chk("att1", digit4, 7'b1111001);
        press(B3, 4'd4);
        chk("att2", digit4, 7'b0100100);
        step(B3, 4'd2);
        chk("long_lock_led", LED, 8'b1100_0000);
        count_lock(8'b1100_0000, LONG, "long_lock_len");
        chk("after_long_led", LED, 8'b0000_0001);

        // Withdraw 4 then an overdraft -> short lock
        press(B3, 4'd0);
        press(B3, 4'd9);
        press(B3, 4'd0);
        press(B2, 4'd4);
        chk("wd_bal1", digit1, 7'b1111001);
        step(B2, 4'd2);
        chk("short_lock_led", LED, 8'b0100_0000);
        count_lock(8'b0100_0000, SHORT, "short_lock_len");
        chk("after_short_led", LED, 8'b0000_1000);
        chk("after_short_bal", digit1, 7'b1111001);

        // Three wrong old-PIN entries -> long lock, logged out
        press(B1, 4'd0);
        press(B2, 4'd0);
        press(B3, 4'd4);
        press(B3, 4'd0);
        step(B3, 4'd14);
        chk("pwold_lock_led", LED, 8'b1100_0000);
        count_lock(8'b1100_0000, LONG, "pwold_lock_len");
        press(B3, 4'd0);
        chk("att_cleared", digit4, 7'b1000000);
        press(B3, 4'd0);
        chk("old_pin_rejected", LED, 8'b0000_0010);
        press(B3, 4'd9);
        chk("relogin_led", LED, 8'b0000_0100);

        // BTN1 and BTN3 together in MENU: BTN1 wins
        press(B1 | B3, 4'd0);
        chk("prio_led", LED, 8'b0000_0001);

        // Fill balance to 250 then probe the 255 ceiling
        press(B3, 4'd0);
        press(B3, 4'd9);
        press(B3, 4'd0);
        for (int i = 0; i < 40 && m_bal < 250; i++)
            press(B3, 4'((250 - m_bal) > 15 ? 15 : (250 - m_bal)));
        chk("bal250_d1", digit1, 7'b1000000);
        press(B3, 4'd15);
        chk("ovf_d3", digit3, 7'b0100100);
        chk("ovf_d2", digit2, 7'b0010010);
        chk("ovf_d1", digit1, 7'b1000000);
        press(B3, 4'd5);
        chk("bal255_d1", digit1, 7'b0010010);
        press(B3, 4'd1);
        chk("ovf255_d1", digit1, 7'b0010010);
        press(B2, 4'd15);
        press(B1, 4'd0);
        press(B2, 4'd0);
        press(B3, 4'd0);
        press(B3, 4'd1);
        step(B3, 4'd2);
        chk("pre_rst_lock", LED, 8'b1100_0000);
        for (int i = 0; i < 10; i++) step(B0, 4'd0);
        do_reset();

        // Random traffic; PIN guesses biased towards the current PIN
        for (int i = 0; i < 2500; i++) begin
            logic [3:0] sw;
            sw = ($urandom_range(0, 1) == 1) ? 4'(m_pin) : 4'($urandom_range(0, 15));
            if ($urandom_range(0, 9) < 4) step(3'($urandom_range(1, 7)), sw);
            else step(B0, sw);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/atm.md
Name: atm

Overview:
- Single-account ATM controller for the Basys board.
- Three push-buttons and a 4-bit switch bank drive a state machine covering card insertion, PIN check, menu, deposit/withdraw, PIN change and timed lockouts.
- Indicates state on 8 LEDs and shows balance/attempt count on four active-low 7-segment digits.
- Top-level user block; button debouncing is done outside this block.

Parameters:
- LOCK_LONG_CYCLES, 500_000_000, lock length after 3 wrong PINs (5 s at 100 MHz).
- LOCK_SHORT_CYCLES, 250_000_000, lock length after an insufficient-funds withdraw (2.5 s).

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-low (one clock; the polarity and synchronicity are fixed)
- BTN3  in  1  enter/confirm/deposit
- BTN2  in  1  withdraw / go to PIN change
- BTN1  in  1  back/logout
- SW  in  4  PIN value or money amount (unsigned 0–15)
- LED  out  8  one-hot state indicator plus lock-type flag
- digit4  out  7  seg code, attempt count
- digit3  out  7  seg code, balance hundreds
- digit2  out  7  seg code, balance tens
- digit1  out  7  seg code, balance units

Behaviour:
- Button inputs:
  - Each button is registered into a prev-flop; press = BTN & ~prev.
  - The action takes effect on the same clock edge where the press is sampled. A 1-cycle pulse must be caught.
  - Priority when several presses coincide: BTN1 > BTN2 > BTN3; the others are dropped.
- Registers:
  - state; pin[3:0], reset 4'b0000; balance[7:0], reset 0; attempts[1:0], reset 0; lock counter; lock_ret; lock_long.
- States and transitions:
  - IDLE: BTN3 → PASS.
  - PASS: BTN3 with SW==pin → MENU and attempts=0. Wrong PIN → attempts+1; on the 3rd wrong → LOCK (long), return to IDLE. BTN1 → IDLE, attempts=0.
  - MENU: BTN3 → MONEY. BTN2 → PW_OLD. BTN1 → IDLE (logout).
  - MONEY:
    - BTN3 deposits SW. If balance+SW > 255 the deposit is rejected and balance is unchanged.
    - BTN2 withdraws SW if SW ≤ balance (equal allowed, result 0). Otherwise balance is unchanged → LOCK (short), return to MONEY.
    - BTN1 → MENU.
  - PW_OLD: BTN3 with SW==pin → PW_NEW, attempts=0. Wrong PIN → attempts+1; on the 3rd wrong → LOCK (long), return to IDLE (logged out). BTN1 → MENU.
  - PW_NEW: BTN3 → pin=SW, → MENU. BTN1 → MENU (pin unchanged).
  - LOCK:
    - All buttons are ignored.
    - Counter is loaded on entry; the state is left exactly LOCK_*_CYCLES clocks after entry.
    - Exit to IDLE clears attempts.
- LED[6:0] one-hot: [0] IDLE, [1] PASS, [2] MENU, [3] MONEY, [4] PW_OLD, [5] PW_NEW, [6] LOCK. LED[7] = 1 only in a long lock.
- Segments: bit order {g,f,e,d,c,b,a}, active-low.
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, blank=1111111.
- Display content:
  - digit4 = attempts in PASS, PW_OLD and LOCK; blank otherwise.
  - digit3..1 = balance in decimal in MENU and MONEY (including leading zeros); blank otherwise.
  - Outputs are combinational from the registers.
- Reset (async, rst=0): state IDLE, pin 0000, balance 0, attempts 0, LED=8'b0000_0001, all digits blank. Reset mid-lock aborts the lock.

Decomposition:
- Package atm_pkg: state enum, segment constants (digits 0–9, blank).
- One sub-module atm_seg7_dec: 4-bit value + blank flag → 7-bit active-low code.
- Binary-to-decimal split of the balance (÷100, ÷10) stays in atm.

Test Plan:
(Use LOCK_LONG_CYCLES=80, LOCK_SHORT_CYCLES=40.)
- Reset; BTN3; SW=0000 + BTN3; BTN3; SW=0101 + BTN3 → LED=0000_1000; digits 0,0,5 (1000000,1000000,0010010).
- From MONEY: BTN1, BTN2, SW=0000+BTN3, SW=1001+BTN3 → MENU, pin=1001. BTN1 → LED=0000_0001.
- BTN3; wrong PINs 0000, 0100, 0010 → digit4 shows 1 then 2. After the 3rd press LED=1100_0000 for exactly 80 cycles, then IDLE; BTN3 during the lock is ignored.
- Login with 1001, MONEY, withdraw 4 → balance 1. Withdraw 2 → LED=0100_0000 for 40 cycles, then MONEY with balance still 1.
- BTN1, BTN2, wrong 0100, 0000, 1110 → long lock, then IDLE with attempts 0; next login requires 1001.
- Pulse BTN1 and BTN3 together in MENU → logout (BTN1 wins). Deposit 15 at balance 250 → rejected. Assert rst mid-lock → IDLE immediately.
